// File: rtl/cabac_ctx_init.sv
// CABAC context-state initializer: streams the init-parameter ROM and writes H.265 initial states.
// Optional CABAC_CTX_INIT_OUT_REG_EN adds one register stage on the context RAM write port.
module cabac_ctx_init #(
    parameter int CTX_NUM = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  slice_qp,
    output logic        busy,
    output logic        done,
    output logic        rom_en,
    output logic [5:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        ctx_we,
    output logic [5:0]  ctx_addr,
    output logic [6:0]  ctx_wdata
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [5:0] LAST = 6'(CTX_NUM - 1);

    state_t      state_q, state_d;
    logic        accept;
    logic        drain_done;
    logic        in_flight;
    logic        done_q;
    logic [5:0]  cnt_q;
    logic [5:0]  qp_r;
    logic        vld_p0;
    logic [5:0]  addr_p0;
    logic        we_p1;
    logic [5:0]  addr_p1;
    logic [6:0]  wdata_p1;

    function automatic logic signed [9:0] clip_pre(input logic signed [13:0] v);
        if (v < 14'sd1)
            return 10'sd1;
        else if (v > 14'sd126)
            return 10'sd126;
        else
            return v[9:0];
    endfunction

    function automatic logic [6:0] ctx_state(input logic [15:0] w, input logic [5:0] qp);
        logic signed [13:0] m_x, q_x, n_x, prod, sum;
        logic signed [9:0]  pre, ps;
        m_x  = {{6{w[15]}}, w[15:8]};
        q_x  = {8'b0, qp};
        n_x  = {6'b0, w[7:0]};
        prod = m_x * q_x;
        // >>> on a signed operand floors toward minus infinity
        sum  = (prod >>> 4) + n_x;
        pre  = clip_pre(sum);
        if (pre <= 10'sd63) begin
            ps = 10'sd63 - pre;
            return {ps[5:0], 1'b0};
        end
        ps = pre - 10'sd64;
        return {ps[5:0], 1'b1};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE:  if (start) begin
                       state_d = READ;
                       accept  = 1'b1;
                   end
            READ:  if (cnt_q == LAST) state_d = DRAIN;
            DRAIN: if (drain_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 6'd0;
            qp_r  <= 6'd0;
        end else if (accept) begin
            cnt_q <= 6'd0;
            qp_r  <= (slice_qp > 6'd51) ? 6'd51 : slice_qp;
        end else if (state_q == READ) begin
            cnt_q <= cnt_q + 6'd1;
        end
    end

    assign rom_en   = (state_q == READ);
    assign rom_addr = cnt_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    // stage p0: ROM access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            addr_p0 <= 6'd0;
        end else begin
            vld_p0  <= rom_en;
            addr_p0 <= rom_addr;
        end
    end

    // stage p1: decode and register the context state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_p1    <= 1'b0;
            addr_p1  <= 6'd0;
            wdata_p1 <= 7'd0;
        end else begin
            we_p1 <= vld_p0;
            if (vld_p0) begin
                addr_p1  <= addr_p0;
                wdata_p1 <= ctx_state(rom_data, qp_r);
            end
        end
    end

`ifdef CABAC_CTX_INIT_OUT_REG_EN
    logic        we_p2;
    logic [5:0]  addr_p2;
    logic [6:0]  wdata_p2;

    // stage p2: retiming register toward a distant context RAM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_p2    <= 1'b0;
            addr_p2  <= 6'd0;
            wdata_p2 <= 7'd0;
        end else begin
            we_p2 <= we_p1;
            if (we_p1) begin
                addr_p2  <= addr_p1;
                wdata_p2 <= wdata_p1;
            end
        end
    end

    assign ctx_we    = we_p2;
    assign ctx_addr  = addr_p2;
    assign ctx_wdata = wdata_p2;
    assign in_flight = vld_p0 | we_p1;
`else
    assign ctx_we    = we_p1;
    assign ctx_addr  = addr_p1;
    assign ctx_wdata = wdata_p1;
    assign in_flight = vld_p0;
`endif

    // the last write is on the port when nothing remains behind it
    assign drain_done = (state_q == DRAIN) && !in_flight && ctx_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            done_q <= 1'b0;
        else
            done_q <= drain_done;
    end

endmodule

// File: tb/tb_cabac_ctx_init.sv
// Directed bench for cabac_ctx_init: hand-computed vectors, full-table runs, busy/done/reset behaviour.
module tb_cabac_ctx_init;

`ifdef CABAC_CTX_INIT_OUT_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  slice_qp = 6'd0;
    logic        busy, done, rom_en, ctx_we;
    logic [5:0]  rom_addr, ctx_addr;
    logic [15:0] rom_data;
    logic [6:0]  ctx_wdata;

    cabac_ctx_init #(.CTX_NUM(N)) dut (
        .clk(clk), .rst(rst), .start(start), .slice_qp(slice_qp),
        .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .ctx_we(ctx_we), .ctx_addr(ctx_addr), .ctx_wdata(ctx_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] rom [64];
    logic [15:0] rom_q;
    always @(posedge clk) begin
        if (rom_en) rom_q <= rom[rom_addr];
        else        rom_q <= 16'hxxxx;
    end
    assign rom_data = rom_q;

    int       nw = 0, ndone = 0, done_cyc = 0;
    int       wr_cyc [256];
    logic [5:0] wr_addr [256];
    logic [6:0] wr_data [256];
    always @(negedge clk) begin
        if (ctx_we && nw < 256) begin
            wr_addr[nw] = ctx_addr;
            wr_data[nw] = ctx_wdata;
            wr_cyc[nw]  = cyc;
            nw = nw + 1;
        end
        if (done) begin
            ndone    = ndone + 1;
            done_cyc = cyc;
        end
    end

    int n_vec = 0, n_miss = 0;
    int t0 = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_state(input logic [15:0] w, input int qp);
        int m, n, q, prod, sh, pre;
        q    = (qp > 51) ? 51 : qp;
        m    = int'($signed(w[15:8]));
        n    = int'(w[7:0]);
        prod = m * q;
        sh   = (prod >= 0) ? prod / 16 : -((-prod + 15) / 16);
        pre  = sh + n;
        if (pre < 1)   pre = 1;
        if (pre > 126) pre = 126;
        if (pre <= 63) return (63 - pre) * 2;
        return (pre - 64) * 2 + 1;
    endfunction

    // Call at negedge+#1; drives start for the next active edge.
    task automatic start_slice(input logic [5:0] qp);
        nw = 0; ndone = 0;
        t0 = cyc;
        start = 1'b1;
        slice_qp = qp;
        @(negedge clk); #1;
        start = 1'b0;
        chk("busy_t1", int'(busy), 1);
        chk("rom_en_t1", int'(rom_en), 1);
        chk("rom_addr_t1", int'(rom_addr), 0);
    endtask

    task automatic finish_slice(input int qp, input bit poke, input bit chain);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk); #1;
            if (poke && cyc == t0 + 10) begin
                start = 1'b1;
                slice_qp = 6'd0;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            return;
        end
        chk("busy_at_done", int'(busy), 0);
        chk("done_cycle", done_cyc - t0, N + LAT);
        chk("write_count", nw, N);
        for (int k = 0; k < N && k < nw; k++) begin
            chk($sformatf("addr[%0d]", k), int'(wr_addr[k]), k);
            chk($sformatf("wcyc[%0d]", k), wr_cyc[k] - t0, LAT + k);
            chk($sformatf("data[%0d]", k), int'(wr_data[k]), ref_state(rom[k], qp));
        end
        if (!chain) begin
            repeat (3) @(negedge clk);
            #1;
            chk("done_single", ndone, 1);
            chk("idle_after", int'(busy), 0);
        end
    endtask

    initial begin
        rom[0] = 16'hfb30;
        rom[1] = 16'h0f30;
        rom[2] = 16'h0a38;
        rom[3] = 16'hec48;
        rom[4] = 16'h8000;
        for (int k = 5; k < 64; k++) rom[k] = 16'((k * 16'h2b4d) ^ 16'h1357);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rom_en", int'(rom_en), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_ctx_we", int'(ctx_we), 0);
        chk("rst_ctx_addr", int'(ctx_addr), 0);
        chk("rst_ctx_wdata", int'(ctx_wdata), 0);
        rst = 1'b0;
        @(negedge clk); #1;

        // qp 32: word 0xfb30 -> 0x32 at address 0
        start_slice(6'd32);
        finish_slice(32, 1'b1, 1'b0);
        chk("vec_fb30_qp32", int'(wr_data[0]), 'h32);
        chk("vec_first_wcyc", wr_cyc[0] - t0, LAT);

        // qp 51: positive, floor-negative and low-clip vectors
        start_slice(6'd51);
        finish_slice(51, 1'b0, 1'b1);
        chk("vec_0f30_qp51", int'(wr_data[1]), 'h3f);
        chk("vec_ec48_qp51", int'(wr_data[3]), 'h6e);
        chk("vec_8000_qp51", int'(wr_data[4]), 'h7c);

        // start issued on the done cycle; qp 63 clamps to 51
        start_slice(6'd63);
        finish_slice(63, 1'b0, 1'b0);
        chk("vec_0a38_qp63", int'(wr_data[2]), 'h2f);

        // abort mid-run
        start_slice(6'd20);
        repeat (19) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_rom_en", int'(rom_en), 0);
        chk("abort_rom_addr", int'(rom_addr), 0);
        chk("abort_ctx_we", int'(ctx_we), 0);
        chk("abort_ctx_addr", int'(ctx_addr), 0);
        chk("abort_ctx_wdata", int'(ctx_wdata), 0);
        chk("abort_writes_before", nw, 21 - LAT);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (80) @(negedge clk);
        #1;
        chk("abort_no_done", ndone, 0);
        chk("abort_no_writes", nw, 21 - LAT);

        start_slice(6'd40);
        finish_slice(40, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
